gost_28147_89_stream: RTL and testbench

Streaming front end for the GOST 28147-89 ECB cipher core (`gost_28147_89`). It drives the core's load/done interface and exposes valid/ready handshakes for key, input blocks and output blocks. The core free-runs and pulses `done` for a single cycle only, so this block sequences each block, holds the per-block mode and S-box select stable, and captures the result. It sits between a bus/DMA block stream and the core.

---
 rtl/gost_pkg.sv | 48 ++++
 rtl/gost_28147_89.sv | 86 ++++++++
 rtl/gost_28147_89_stream.sv | 118 +++++++++++
 tb/tb_gost_28147_89_stream.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gost_pkg.sv
// Shared types, constants and S-box tables for the GOST 28147-89 core and its stream front end.
package gost_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } gost_stream_state_t;

  // Feistel rounds per block.
  localparam int unsigned GOST_ROUNDS = 32;
  // Edges from block accept to the result being held in the output register.
  localparam int unsigned GOST_STREAM_LATENCY = 33;

  // S-box rows, one per input nibble position (row 0 = least significant nibble).
  // Entry 0 of each row sits in the top nibble so the table reads left to right.
  localparam logic [63:0] GOST_SBOX_Z [8] = '{
    64'hC462A5B9E8D703F1,
    64'h68239A5C1E47BD0F,
    64'hB3582FADE174C960,
    64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C,
    64'h5DF692CAB78143E0,
    64'h8E25691CF4B0DA37,
    64'h17ED05834FA69CB2
  };

  localparam logic [63:0] GOST_SBOX_TEST [8] = '{
    64'h4A92D80E6B1C7F53,
    64'hEB4C6DFA23810759,
    64'h581DA342EFC7609B,
    64'h7DA1089FE46CB253,
    64'h6C715FD84A9E03B2,
    64'h4BA0721D36859CFE,
    64'hDB413F590AE7682C,
    64'h1FD057A4923E6B8C
  };

  // Substitute one nibble; sel = 0 picks the Z set, sel = 1 the test set.
  function automatic logic [3:0] gost_sbox(input logic       sel,
                                           input logic [2:0] row,
                                           input logic [3:0] x);
    logic [63:0] r;
    r = sel ? GOST_SBOX_TEST[row] : GOST_SBOX_Z[row];
    // Entry x lives at bit 63 - 4x, i.e. base 4 * (15 - x).
    return r[{~x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/gost_28147_89.sv
// GOST 28147-89 ECB core: one Feistel round per clock, free-running after load.
// load restarts a block; done pulses one cycle after the 32nd round and then
// every 32 cycles as the core keeps turning over the state.
module gost_28147_89
  import gost_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,    // 0 = encrypt, 1 = decrypt
  input  logic         select,  // S-box set
  input  logic         load,
  input  logic         kload,
  input  logic [255:0] key,     // K0 in the MSBs
  input  logic [63:0]  pdata,
  output logic [63:0]  cdata,
  output logic         done
);

  logic [255:0] key_q, key_d;
  logic [31:0]  n1_q, n1_d;
  logic [31:0]  n2_q, n2_d;
  logic [4:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [2:0]   kidx;
  logic [31:0]  rkey;
  logic [31:0]  sum;
  logic [31:0]  sub;
  logic [31:0]  f_out;

  // Round function: key word select, add, substitute, rotate left by 11.
  always_comb begin
    kidx = rnd_q[2:0];
    if (!mode) begin
      // Encrypt: K0..K7 three times, then K7..K0.
      if (rnd_q >= 5'd24) kidx = ~rnd_q[2:0];
    end else begin
      // Decrypt: K0..K7 once, then K7..K0 three times.
      if (rnd_q >= 5'd8) kidx = ~rnd_q[2:0];
    end
    rkey = key_q[{~kidx, 5'b00000} +: 32];
    sum  = n1_q + rkey;
    sub  = '0;
    for (int j = 0; j < 8; j++) begin
      sub[4*j +: 4] = gost_sbox(select, 3'(j), sum[4*j +: 4]);
    end
    f_out = {sub[20:0], sub[31:21]};
  end

  // Next-state for key, block halves, round index and done pulse.
  always_comb begin
    key_d  = kload ? key : key_q;
    n1_d   = n2_q ^ f_out;
    n2_d   = n1_q;
    rnd_d  = rnd_q + 5'd1;
    done_d = (rnd_q == 5'(GOST_ROUNDS - 1));
    if (load) begin
      n1_d   = pdata[31:0];
      n2_d   = pdata[63:32];
      rnd_d  = '0;
      done_d = 1'b0;
    end
  end

  // Core state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q  <= '0;
      n1_q   <= '0;
      n2_q   <= '0;
      rnd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      key_q  <= key_d;
      n1_q   <= n1_d;
      n2_q   <= n2_d;
      rnd_q  <= rnd_d;
      done_q <= done_d;
    end
  end

  // Every round swaps the halves; emitting {n1, n2} undoes the last swap.
  assign cdata = {n1_q, n2_q};
  assign done  = done_q;

endmodule

// File: rtl/gost_28147_89_stream.sv
// Valid/ready front end for the GOST 28147-89 core: sequences one block at a
// time, holds mode/select for the whole run and captures the result.
module gost_28147_89_stream
  import gost_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic         in_mode,
  input  logic         in_select,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         busy
);

  gost_stream_state_t state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               select_q, select_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_data_q, out_data_d;

  logic               key_accept;
  logic               in_accept;
  logic               capture;
  logic               core_done;
  logic [63:0]        core_cdata;

  // Handshakes, FSM next state, round counter and output register.
  always_comb begin
    key_ready   = (state_q == StIdle);
    // A pending key wins; a block waits until the capture slot is free or draining.
    in_ready    = (state_q == StIdle) && !key_valid && (!out_valid_q || out_ready);
    key_accept  = key_ready && key_valid;
    in_accept   = in_ready && in_valid;
    // done outside RUN is a stale free-run pulse and is ignored.
    capture     = (state_q == StRun) && core_done;

    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    select_d    = select_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      StIdle: begin
        if (in_accept) begin
          state_d  = StRun;
          cnt_d    = '0;
          mode_d   = in_mode;
          select_d = in_select;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 6'd1;
        if (core_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = core_cdata;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      select_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      select_q    <= select_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Simulation cross-check: the core's done must line up with our round count.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StRun)) begin
      assert (core_done == (cnt_q == 6'(GOST_STREAM_LATENCY - 1)));
    end
  end

  gost_28147_89 u_core (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode_q),
    .select (select_q),
    .load   (in_accept),
    .kload  (key_accept),
    .key    (key),
    .pdata  (in_data),
    .cdata  (core_cdata),
    .done   (core_done)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == StRun);

endmodule

// File: tb/tb_gost_28147_89_stream.sv
// Self-checking bench for gost_28147_89_stream against a behavioural GOST model.
module tb_gost_28147_89_stream;

  localparam int unsigned Latency = 33;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [255:0] key;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_mode;
  logic         in_select;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic         busy;

  int unsigned  checks = 0;
  int unsigned  failures = 0;
  int unsigned  cyc = 0;

  logic [255:0] model_key;
  logic [63:0]  exp_q[$];
  int unsigned  acc_q[$];
  logic         lat_on;
  logic [63:0]  sb0 [8];
  logic [63:0]  sb1 [8];

  gost_28147_89_stream dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_select (in_select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Textbook GOST 28147-89: N1 = low word, N2 = high word, no swap after round 32.
  function automatic logic [63:0] model(input logic [255:0] k, input logic [63:0] b,
                                        input logic dec, input logic sel);
    logic [31:0] kw [8];
    int          sched [32];
    logic [31:0] a, c, t, s, f;
    logic [63:0] row;
    int          x;
    for (int i = 0; i < 8; i++) kw[i] = k[255 - 32*i -: 32];
    for (int r = 0; r < 32; r++) sched[r] = (r < 24) ? (r % 8) : (7 - (r % 8));
    a = b[31:0];
    c = b[63:32];
    s = '0;
    for (int r = 0; r < 32; r++) begin
      t = a + kw[dec ? sched[31 - r] : sched[r]];
      for (int j = 0; j < 8; j++) begin
        row = sel ? sb1[j] : sb0[j];
        x = int'(t[4*j +: 4]);
        s[4*j +: 4] = row[63 - 4*x -: 4];
      end
      f = (s << 11) | (s >> 21);
      {a, c} = {c ^ f, a};
    end
    return {a, c};
  endfunction

  // Scoreboard: every popped result must match the oldest expected block.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        check_eq("out_data", out_data, exp_q.pop_front());
        if (lat_on) check_eq("latency", 64'(cyc - acc_q.pop_front()), 64'(Latency));
        else void'(acc_q.pop_front());
      end
    end
  end

  task automatic load_key(input logic [255:0] k);
    bit got = 0;
    @(posedge clk); #1;
    key_valid = 1'b1;
    key = k;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (key_ready) begin got = 1; break; end
    end
    if (!got) check_eq("key_accept", 64'(key_ready), 64'd1);
    else model_key = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key = rand256();
  endtask

  task automatic send_block(input logic [63:0] d, input logic m, input logic s,
                            input bit push, input logic [63:0] expv);
    bit got = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = d;
    in_mode = m;
    in_select = s;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; break; end
    end
    if (!got) begin
      check_eq("in_accept", 64'(in_ready), 64'd1);
    end else if (push) begin
      exp_q.push_back(expv);
      acc_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
    // Scramble block-side inputs during the run; they must not matter.
    in_valid = 1'b0;
    in_data = rand64();
    in_mode = ~m;
    in_select = ~s;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] pt, ct, d, held;
    logic [255:0] k2;
    logic m, s, flag_a, flag_b;

    sb0 = '{64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960,
            64'hC821D4F670A53E9B, 64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0,
            64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2};
    sb1 = '{64'h4A92D80E6B1C7F53, 64'hEB4C6DFA23810759, 64'h581DA342EFC7609B,
            64'h7DA1089FE46CB253, 64'h6C715FD84A9E03B2, 64'h4BA0721D36859CFE,
            64'hDB413F590AE7682C, 64'h1FD057A4923E6B8C};

    rst = 1'b1;
    key_valid = 1'b0;
    key = '0;
    in_valid = 1'b0;
    in_data = '0;
    in_mode = 1'b0;
    in_select = 1'b0;
    out_ready = 1'b1;
    lat_on = 1'b1;
    model_key = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    check_eq("rst_key_ready", 64'(key_ready), 64'd1);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known block, zero key, both S-box sets, encrypt then decrypt back.
    pt = 64'h0123456789ABCDEF;
    load_key(256'h0);
    for (int sel = 0; sel < 2; sel++) begin
      ct = model(model_key, pt, 1'b0, sel[0]);
      send_block(pt, 1'b0, sel[0], 1, ct);
      drain();
      send_block(ct, 1'b1, sel[0], 1, pt);
      drain();
    end

    // Random key, four back-to-back random blocks.
    load_key(rand256());
    for (int i = 0; i < 4; i++) begin
      d = rand64();
      m = 1'($urandom);
      s = 1'($urandom);
      send_block(d, m, s, 1, model(model_key, d, m, s));
    end
    drain();

    // Output stall: result held, new block blocked, nothing lost on release.
    lat_on = 1'b0;
    out_ready = 1'b0;
    d = rand64();
    send_block(d, 1'b0, 1'b1, 1, model(model_key, d, 1'b0, 1'b1));
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check_eq("hold_valid", 64'(out_valid), 64'd1);
    held = out_data;
    check_eq("hold_data", held, model(model_key, d, 1'b0, 1'b1));
    @(posedge clk); #1;
    d = rand64();
    in_valid = 1'b1;
    in_data = d;
    in_mode = 1'b1;
    in_select = 1'b0;
    flag_a = 1'b0;
    flag_b = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (in_ready) flag_a = 1'b1;
      if (out_data !== held || !out_valid) flag_b = 1'b1;
    end
    check_eq("hold_in_ready", 64'(flag_a), 64'd0);
    check_eq("hold_stable", 64'(flag_b), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("release_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(model(model_key, d, 1'b1, 1'b0));
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    lat_on = 1'b1;

    // Key and block offered together: key first, block next cycle with new key.
    k2 = rand256();
    d = rand64();
    @(posedge clk); #1;
    key_valid = 1'b1;
    key = k2;
    in_valid = 1'b1;
    in_data = d;
    in_mode = 1'b0;
    in_select = 1'b0;
    @(negedge clk);
    check_eq("both_key_ready", 64'(key_ready), 64'd1);
    check_eq("both_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    key_valid = 1'b0;
    model_key = k2;
    @(negedge clk);
    check_eq("both_in_ready_next", 64'(in_ready), 64'd1);
    exp_q.push_back(model(k2, d, 1'b0, 1'b0));
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Key offered during RUN is refused; the block keeps the old key.
    d = rand64();
    send_block(d, 1'b0, 1'b1, 1, model(model_key, d, 1'b0, 1'b1));
    key_valid = 1'b1;
    key = rand256();
    flag_a = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (key_ready) flag_a = 1'b1;
    end
    check_eq("run_key_ready", 64'(flag_a), 64'd0);
    @(posedge clk); #1;
    key_valid = 1'b0;
    drain();

    // Reset at round 15 abandons the block and clears the key.
    send_block(rand64(), 1'b0, 1'b0, 0, 64'd0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_key = '0;
    @(negedge clk);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    flag_a = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) flag_a = 1'b1;
    end
    check_eq("midrst_no_output", 64'(flag_a), 64'd0);
    d = rand64();
    send_block(d, 1'b0, 1'b0, 1, model(256'h0, d, 1'b0, 1'b0));
    drain();
    load_key(rand256());
    d = rand64();
    send_block(d, 1'b1, 1'b1, 1, model(model_key, d, 1'b1, 1'b1));
    drain();

    // Long idle: free-running done pulses must not produce output.
    flag_a = 1'b0;
    flag_b = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (out_valid) flag_a = 1'b1;
      if (busy) flag_b = 1'b1;
    end
    check_eq("idle_out_valid", 64'(flag_a), 64'd0);
    check_eq("idle_busy", 64'(flag_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
